// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for an 8:1 registered mux: a prescaler paces service slots,
// and each slot grants the next requesting channel after the last one served.
module mux_rr_scheduler #(
    parameter int unsigned DIVISOR = 50_000_000,
    parameter int unsigned WIDTH   = 8
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic [7:0]         req,
    input  logic [8*WIDTH-1:0] data_in,
    input  logic               hold,
    output logic               tick,
    output logic [2:0]         sel,
    output logic [7:0]         grant,
    output logic [7:0]         ack,
    output logic [WIDTH-1:0]   data_out,
    output logic               valid,
    output logic               state_dbg
);

    typedef enum logic {ST_RUN = 1'b0, ST_FROZEN = 1'b1} state_t;

    localparam logic [26:0] LAST = 27'(DIVISOR - 1);

    state_t             state_q, state_d;
    logic [26:0]        cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic [2:0]         sel_q, sel_d;
    logic [7:0]         grant_q, grant_d;
    logic [7:0]         ack_q, ack_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;

    logic               slot;
    logic               win_found;
    logic [2:0]         win_idx;
    logic [2:0]         cand;
    logic [7:0]         win_onehot;

    // Hold gates the slot edge directly so a hold of N cycles costs exactly N cycles;
    // the registered state mirrors hold for observation.
    assign slot = !hold && (cnt_q == LAST);

    // Search starts one past the last served channel; k=8 wraps back to sel itself.
    always_comb begin
        win_found = 1'b0;
        win_idx   = sel_q;
        cand      = sel_q;
        for (int k = 1; k <= 8; k++) begin
            cand = sel_q + 3'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_onehot = 8'b1 << win_idx;

    always_comb begin
        state_d = hold ? ST_FROZEN : ST_RUN;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        valid_d = 1'b0;
        ack_d   = 8'h00;
        sel_d   = sel_q;
        grant_d = grant_q;
        data_d  = data_q;
        if (!hold) begin
            cnt_d = slot ? 27'd0 : cnt_q + 27'd1;
        end
        if (slot) begin
            tick_d  = 1'b1;
            grant_d = 8'h00;
            if (win_found) begin
                valid_d = 1'b1;
                ack_d   = win_onehot;
                grant_d = win_onehot;
                sel_d   = win_idx;
                data_d  = data_in[32'(win_idx)*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 27'd0;
            tick_q  <= 1'b0;
            sel_q   <= 3'd7;
            grant_q <= 8'h00;
            ack_q   <= 8'h00;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign tick      = tick_q;
    assign sel       = sel_q;
    assign grant     = grant_q;
    assign ack       = ack_q;
    assign data_out  = data_q;
    assign valid     = valid_q;
    assign state_dbg = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against a slot-level behavioural model.
module tb_mux_rr_scheduler;

    localparam int D = 4;
    localparam int W = 8;

    logic           clk_in = 1'b0;
    logic           reset_n;
    logic [7:0]     req;
    logic [8*W-1:0] data_in;
    logic           hold;
    logic           tick;
    logic [2:0]     sel;
    logic [7:0]     grant;
    logic [7:0]     ack;
    logic [W-1:0]   data_out;
    logic           valid;
    logic           state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    mux_rr_scheduler #(.DIVISOR(D), .WIDTH(W)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .req(req), .data_in(data_in),
        .hold(hold), .tick(tick), .sel(sel), .grant(grant), .ack(ack),
        .data_out(data_out), .valid(valid), .state_dbg(state_dbg)
    );

    // clock
    always #5 clk_in = ~clk_in;

    // model: slot occurs on every D-th unheld edge since reset
    int           m_runs;
    logic         m_tick, m_valid;
    logic [2:0]   m_sel;
    logic [7:0]   m_grant, m_ack;
    logic [W-1:0] m_data;

    function automatic int pick(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (r[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            m_runs  <= 0;
            m_tick  <= 1'b0;
            m_valid <= 1'b0;
            m_sel   <= 3'd7;
            m_grant <= 8'h00;
            m_ack   <= 8'h00;
            m_data  <= '0;
        end else begin
            m_tick  <= 1'b0;
            m_valid <= 1'b0;
            m_ack   <= 8'h00;
            if (!hold) begin
                m_runs <= m_runs + 1;
                if ((m_runs + 1) % D == 0) begin
                    int w;
                    w = pick(req, int'(m_sel));
                    m_tick <= 1'b1;
                    if (w < 0) begin
                        m_grant <= 8'h00;
                    end else begin
                        m_valid <= 1'b1;
                        m_sel   <= 3'(w);
                        m_grant <= 8'h01 << w;
                        m_ack   <= 8'h01 << w;
                        m_data  <= data_in[w*W +: W];
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // scoreboard compare, every cycle
    always @(negedge clk_in) begin
        check("model_tick",  64'(tick),     64'(m_tick));
        check("model_valid", 64'(valid),    64'(m_valid));
        check("model_ack",   64'(ack),      64'(m_ack));
        check("model_grant", 64'(grant),    64'(m_grant));
        check("model_sel",   64'(sel),      64'(m_sel));
        check("model_data",  64'(data_out), 64'(m_data));
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_in);
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] v);
        data_in[ch*W +: W] = v;
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 8'h00;
        hold    = 1'b0;
        data_in = '0;
        cycles(3);
        check("rst_sel",   64'(sel), 64'd7);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_data",  64'(data_out), 64'd0);
        check("rst_tick",  64'(tick), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_ack",   64'(ack), 64'd0);

        // idle after release: ticks on cycles 4, 8, 12 only
        reset_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_in);
            check("idle_tick",  64'(tick), 64'(c % 4 == 0));
            check("idle_valid", 64'(valid), 64'd0);
            check("idle_grant", 64'(grant), 64'd0);
        end

        // single requester
        req = 8'h04;
        set_ch(2, 8'hA5);
        for (int s = 0; s < 2; s++) begin
            cycles(4);
            check("single_sel",   64'(sel), 64'd2);
            check("single_grant", 64'(grant), 64'h04);
            check("single_ack",   64'(ack), 64'h04);
            check("single_valid", 64'(valid), 64'd1);
            check("single_data",  64'(data_out), 64'hA5);
        end

        // full contention from sel=2
        req = 8'hFF;
        for (int i = 0; i < 8; i++) set_ch(i, 8'(8'h10 + i));
        for (int s = 1; s <= 12; s++) begin
            cycles(4);
            check("rr_sel",  64'(sel), 64'((2 + s) % 8));
            check("rr_data", 64'(data_out), 64'(8'h10 + (2 + s) % 8));
        end

        // wrap/skip from sel=6
        req = 8'h03;
        cycles(4); check("wrap_sel0", 64'(sel), 64'd0);
        cycles(4); check("wrap_sel1", 64'(sel), 64'd1);
        cycles(4); check("wrap_sel2", 64'(sel), 64'd0);

        // hold for 3 cycles when the counter is at 2
        cycles(2);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("hold_tick",  64'(tick), 64'd0);
            check("hold_sel",   64'(sel), 64'd0);
            check("hold_grant", 64'(grant), 64'h01);
            check("hold_data",  64'(data_out), 64'h10);
        end
        hold = 1'b0;
        @(negedge clk_in); check("hold_late_tick0", 64'(tick), 64'd0);
        @(negedge clk_in); check("hold_late_tick1", 64'(tick), 64'd1);
        check("hold_after_sel", 64'(sel), 64'd1);

        // reset mid-slot with grant=8'h08
        req = 8'h08;
        set_ch(3, 8'h5C);
        cycles(4);
        check("mid_grant", 64'(grant), 64'h08);
        cycles(2);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_sel",   64'(sel), 64'd7);
        check("mid_rst_grant", 64'(grant), 64'd0);
        check("mid_rst_data",  64'(data_out), 64'd0);
        @(negedge clk_in);
        reset_n = 1'b1;
        cycles(3);
        check("mid_rel_tick0", 64'(tick), 64'd0);
        @(negedge clk_in);
        check("mid_rel_tick1", 64'(tick), 64'd1);
        check("mid_rel_grant", 64'(grant), 64'h08);
        check("mid_rel_data",  64'(data_out), 64'h5C);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0:       req = 8'h00;
                1:       req = 8'h01 << $urandom_range(0, 7);
                2:       req = 8'($urandom);
                default: req = 8'hFF;
            endcase
            hold    = ($urandom_range(0, 9) == 0);
            reset_n = ($urandom_range(0, 199) != 0);
            data_in = {$urandom, $urandom};
            @(negedge clk_in);
        end
        reset_n = 1'b1;
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
